// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - funct3 access codes (B, H, W, BU, HU)
//   - responder FSM state encoding
//   - lane-width constants for a 32-bit word split into byte lanes
//   - helpers that turn (funct3, addr[1:0]) into a byte-enable mask and an
//     access-error flag
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = WORD_W / BYTE_W;

    // Byte-enable mask for a store of the given size at byte offset lo.
    // Illegal store sizes produce an empty mask.
    function automatic logic [NUM_LANES-1:0] lane_mask(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [NUM_LANES-1:0] mask;
        mask = '0;
        case (f3)
            F3_B:    mask = 4'b0001 << lo;
            F3_H:    mask = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    mask = 4'b1111;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    // Access error: illegal size code for the direction, or an address that
    // is not naturally aligned to the access size.
    function automatic logic access_err(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic err;
        err = 1'b0;
        if (is_store) begin
            case (f3)
                F3_B:    err = 1'b0;
                F3_H:    err = lo[0];
                F3_W:    err = |lo;
                default: err = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = lo[0];
                F3_W:        err = |lo;
                default:     err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// ---------------------------------------------------------------------------
// dmem_sram
// Word-wide single-port synchronous RAM with per-byte write enables and a
// registered read port.
// Ports:
//   i_clk    clock, rising edge
//   i_addr   word index
//   i_be     byte-lane write enables (lane 0 = bits [7:0])
//   i_wdata  write data, already replicated onto the enabled lanes
//   i_re     read enable; o_rdata updates only on edges where it is high
//   o_rdata  registered read data
// ---------------------------------------------------------------------------
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [NUM_LANES-1:0]  i_be,
    input  logic [WORD_W-1:0]     i_wdata,
    input  logic                  i_re,
    output logic [WORD_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_rdata;

    // Reads and writes never target the same edge (the responder only
    // accepts one request per edge), so read-during-write ordering is moot.
    always_ff @(posedge i_clk) begin
        for (int li = 0; li < NUM_LANES; li++) begin
            if (i_be[li]) begin
                r_mem[i_addr][li*BYTE_W +: BYTE_W] <= i_wdata[li*BYTE_W +: BYTE_W];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Far end of the CPU load/store port. Accepts one request, performs a
// byte/half/word store or load, and answers with a one-cycle rdy pulse
// (plus err for misaligned / illegal-size accesses, which never touch RAM).
// Ports:
//   clk_w_i         clock, rising edge
//   res_w_i_l       synchronous active-low reset
//   mem_addr_w_i    byte address
//   mem_data_w_i    store data, right-justified
//   mem_wr_w_i_h    store request (wins over a simultaneous load)
//   mem_rd_w_i_h    load request
//   mem_funct3_w_i  size/sign code
//   mem_data_w_o    extended load data (held between loads)
//   mem_rdy_w_o_h   completion pulse, one cycle after accept
//   mem_err_w_o_h   error pulse, coincident with rdy
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_l,
    input  logic [31:0]       mem_addr_w_i,
    input  logic [31:0]       mem_data_w_i,
    input  logic              mem_wr_w_i_h,
    input  logic              mem_rd_w_i_h,
    input  logic [2:0]        mem_funct3_w_i,
    output logic [31:0]       mem_data_w_o,
    output logic              mem_rdy_w_o_h,
    output logic              mem_err_w_o_h
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_is_load;
    logic                  r_err;
    logic [1:0]            r_lane;
    logic [2:0]            r_f3;
    logic [WORD_W-1:0]     r_hold;

    logic                  w_accept;
    logic                  w_is_store;
    logic                  w_err_now;
    logic [NUM_LANES-1:0]  w_be;
    logic [WORD_W-1:0]     w_wdata;
    logic                  w_re;
    logic [WORD_W-1:0]     w_rdata;
    logic [BYTE_W-1:0]     w_byte;
    logic [HALF_W-1:0]     w_half;
    logic [WORD_W-1:0]     w_load_ext;
    logic                  w_unused_addr;

    // Address bits above the RAM index are ignored, so accesses wrap.
    assign w_unused_addr = ^mem_addr_w_i[31:DEPTH_LOG2+2];

    assign w_is_store = mem_wr_w_i_h;
    assign w_accept   = (r_state == ST_IDLE) && (mem_wr_w_i_h || mem_rd_w_i_h);
    assign w_err_now  = access_err(w_is_store, mem_funct3_w_i, mem_addr_w_i[1:0]);

    // A store coinciding with reset must not land in RAM.
    assign w_be = (w_accept && w_is_store && !w_err_now && res_w_i_l)
                ? lane_mask(mem_funct3_w_i, mem_addr_w_i[1:0]) : '0;
    assign w_re = w_accept && !w_is_store;

    // Replicate the right-justified store data onto every lane it could
    // occupy; the byte enables pick the real destination.
    always_comb begin
        w_wdata = mem_data_w_i;
        case (mem_funct3_w_i)
            F3_B:    w_wdata = {NUM_LANES{mem_data_w_i[BYTE_W-1:0]}};
            F3_H:    w_wdata = {2{mem_data_w_i[HALF_W-1:0]}};
            default: w_wdata = mem_data_w_i;
        endcase
    end

    dmem_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_sram (
        .i_clk   (clk_w_i),
        .i_addr  (mem_addr_w_i[DEPTH_LOG2+1:2]),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

    // FSM: state register
    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request attributes captured at accept; load result latched at the end
    // of RESP so the output keeps showing the last good load.
    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_l) begin
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_lane    <= 2'b00;
            r_f3      <= 3'b000;
            r_hold    <= '0;
        end else begin
            if (w_accept) begin
                r_is_load <= !w_is_store;
                r_err     <= w_err_now;
                r_lane    <= mem_addr_w_i[1:0];
                r_f3      <= mem_funct3_w_i;
            end
            if ((r_state == ST_RESP) && r_is_load && !r_err) begin
                r_hold <= w_load_ext;
            end
        end
    end

    // Lane extraction and sign/zero extension of the registered RAM word.
    assign w_byte = w_rdata[{r_lane, 3'b000} +: BYTE_W];
    assign w_half = w_rdata[{r_lane[1], 4'b0000} +: HALF_W];

    always_comb begin
        w_load_ext = '0;
        case (r_f3)
            F3_B:    w_load_ext = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_BU:   w_load_ext = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
            F3_H:    w_load_ext = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_HU:   w_load_ext = {{(WORD_W-HALF_W){1'b0}}, w_half};
            F3_W:    w_load_ext = w_rdata;
            default: w_load_ext = '0;
        endcase
    end

    // FSM: outputs. Reset wins over a pending response, so it also masks the
    // pulse of a RESP cycle in which reset is being asserted.
    always_comb begin
        mem_rdy_w_o_h = 1'b0;
        mem_err_w_o_h = 1'b0;
        mem_data_w_o  = r_hold;
        if (!res_w_i_l) begin
            mem_data_w_o = '0;
        end else if (r_state == ST_RESP) begin
            mem_rdy_w_o_h = 1'b1;
            mem_err_w_o_h = r_err;
            if (r_err) begin
                mem_data_w_o = '0;
            end else if (r_is_load) begin
                mem_data_w_o = w_load_ext;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Byte-array reference model of a 4 KiB data memory; a per-cycle compare
// process checks rdy/err/data against it, directed transactions carry
// hand-computed literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        res_l;
    logic [31:0] addr, wdata;
    logic        wr, rd;
    logic [2:0]  f3;
    logic [31:0] data_o;
    logic        rdy, err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2 (10),
        .INIT_FILE  ("")
    ) dut (
        .clk_w_i        (clk),
        .res_w_i_l      (res_l),
        .mem_addr_w_i   (addr),
        .mem_data_w_i   (wdata),
        .mem_wr_w_i_h   (wr),
        .mem_rd_w_i_h   (rd),
        .mem_funct3_w_i (f3),
        .mem_data_w_o   (data_o),
        .mem_rdy_w_o_h  (rdy),
        .mem_err_w_o_h  (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  bm [0:4095];
    logic        exp_rdy  = 1'b0;
    logic        exp_err  = 1'b0;
    logic [31:0] exp_data = '0;
    logic [31:0] hold     = '0;
    bit          chk_en   = 1'b0;

    logic        c_rdy, c_err;
    logic [31:0] c_data;

    // Per-cycle comparison, away from the active edge. Reset low forces
    // every output quiet.
    always @(negedge clk) begin
        if (chk_en) begin
            c_rdy  = res_l ? exp_rdy  : 1'b0;
            c_err  = res_l ? exp_err  : 1'b0;
            c_data = res_l ? exp_data : 32'h0;
            checks++;
            if (rdy !== c_rdy || err !== c_err || data_o !== c_data) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t rdy=%b want %b err=%b want %b data=%h want %h",
                         $time, rdy, c_rdy, err, c_err, data_o, c_data);
            end
        end
    end

    // Size in bytes is 2^funct3[1:0]; legal codes depend on direction;
    // accesses must be naturally aligned.
    function automatic bit model_err(input bit is_st, input logic [2:0] f, input logic [31:0] a);
        int n;
        bit legal;
        n = 1 << f[1:0];
        if (is_st) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
        else       legal = (f[1:0] != 2'b11) && !(f[2] && f[1]);
        if (!legal) return 1'b1;
        return (int'(a[11:0]) % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
        int     n, base;
        longint v;
        n    = 1 << f[1:0];
        base = int'(a[11:0]);
        v    = 0;
        for (int i = 0; i < n; i++) v += longint'(bm[(base + i) % 4096]) << (8 * i);
        if (!f[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int n, base;
        n    = 1 << f[1:0];
        base = int'(a[11:0]);
        for (int i = 0; i < n; i++) bm[(base + i) % 4096] = d[8*i +: 8];
    endtask

    task automatic lit_chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // One transaction, entered 1 time unit after a rising edge with the DUT
    // idle. mode 0: normal; 1: reset asserted during RESP; 2: reset on the
    // accept edge.
    task automatic txn(input bit do_rd, input bit do_wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input int mode,
                       input bit use_lit, input logic [31:0] lit, input bit lit_err,
                       input string nm);
        bit          st, e;
        logic [31:0] v;
        rd = do_rd; wr = do_wr; f3 = f; addr = a; wdata = d;
        if (mode == 2) res_l = 1'b0;
        @(posedge clk); #1;
        if (mode == 2) begin
            hold = '0; exp_rdy = 1'b0; exp_err = 1'b0; exp_data = '0;
            res_l = 1'b1; rd = 1'b0; wr = 1'b0;
            #1;
            if (use_lit) lit_chk({nm, "_rdy"}, {31'b0, rdy}, 32'h0);
            $display("txn %-12s rd=%0b wr=%0b f3=%0d addr=%h data=%h (reset on accept)", nm, do_rd, do_wr, f, a, d);
            @(posedge clk); #1;
            return;
        end
        st = do_wr;
        e  = model_err(st, f, a);
        v  = '0;
        if (st) begin
            if (!e) model_store(f, a, d);
            exp_data = e ? 32'h0 : hold;
        end else begin
            v = model_load(f, a);
            exp_data = e ? 32'h0 : v;
        end
        exp_rdy = 1'b1;
        exp_err = e;
        if (mode == 1) begin
            res_l = 1'b0;
            #1;
        end
        if (use_lit) begin
            lit_chk({nm, "_data"}, data_o, lit);
            lit_chk({nm, "_err"}, {31'b0, err}, {31'b0, lit_err});
            lit_chk({nm, "_rdy"}, {31'b0, rdy}, (mode == 1) ? 32'h0 : 32'h1);
        end
        $display("txn %-12s rd=%0b wr=%0b f3=%0d addr=%h data=%h -> rdy=%0b err=%0b out=%h",
                 nm, do_rd, do_wr, f, a, d, rdy, err, data_o);
        @(posedge clk); #1;
        if (mode == 1) begin
            hold  = '0;
            res_l = 1'b1;
        end else if (!st && !e) begin
            hold = v;
        end
        exp_rdy = 1'b0; exp_err = 1'b0; exp_data = hold;
        rd = 1'b0; wr = 1'b0;
        addr = $urandom; wdata = $urandom; f3 = 3'($urandom);
    endtask

    initial begin
        int          op, mode, gap;
        logic [2:0]  rf;
        logic [31:0] ra;
        res_l = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit_chk("reset_data", data_o, 32'h0);
        lit_chk("reset_rdy", {31'b0, rdy}, 32'h0);
        res_l = 1'b1;
        @(posedge clk); #1;

        txn(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0,        0, "sw_10");
        txn(1, 0, 3'd2, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF, 0, "lw_10");
        txn(0, 1, 3'd0, 32'h11, 32'hAAAAAA55, 0, 1, 32'hDEADBEEF, 0, "sb_11");
        txn(1, 0, 3'd2, 32'h10, 32'h0,        0, 1, 32'hDEAD55EF, 0, "lw_10b");
        txn(0, 1, 3'd2, 32'h20, 32'h00008080, 0, 1, 32'hDEAD55EF, 0, "sw_20");
        txn(1, 0, 3'd0, 32'h20, 32'h0,        0, 1, 32'hFFFFFF80, 0, "lb_20");
        txn(1, 0, 3'd4, 32'h20, 32'h0,        0, 1, 32'h00000080, 0, "lbu_20");
        txn(1, 0, 3'd1, 32'h20, 32'h0,        0, 1, 32'hFFFF8080, 0, "lh_20");
        txn(1, 0, 3'd5, 32'h20, 32'h0,        0, 1, 32'h00008080, 0, "lhu_20");
        txn(1, 0, 3'd1, 32'h21, 32'h0,        0, 1, 32'h0,        1, "lh_21_err");
        txn(0, 1, 3'd2, 32'h22, 32'h11111111, 0, 1, 32'h0,        1, "sw_22_err");
        txn(1, 0, 3'd2, 32'h20, 32'h0,        0, 1, 32'h00008080, 0, "lw_20");
        txn(1, 0, 3'd3, 32'h20, 32'h0,        0, 1, 32'h0,        1, "ld011_err");
        txn(0, 1, 3'd2, 32'h24, 32'h11223344, 0, 1, 32'h00008080, 0, "sw_24");
        txn(0, 1, 3'd4, 32'h24, 32'h000000AA, 0, 1, 32'h0,        1, "st100_err");
        txn(0, 1, 3'd1, 32'h26, 32'h0000BEEF, 0, 1, 32'h00008080, 0, "sh_26");
        txn(1, 0, 3'd2, 32'h24, 32'h0,        0, 1, 32'hBEEF3344, 0, "lw_24");
        txn(0, 1, 3'd2, 32'h1000, 32'h12345678, 0, 1, 32'hBEEF3344, 0, "sw_1000");
        txn(1, 0, 3'd2, 32'h0,  32'h0,        0, 1, 32'h12345678, 0, "lw_0_wrap");
        txn(1, 0, 3'd2, 32'h10, 32'h0,        1, 1, 32'h0,        0, "lw_rst_resp");
        lit_chk("after_rst_data", data_o, 32'h0);
        txn(1, 0, 3'd2, 32'h10, 32'h0,        0, 1, 32'hDEAD55EF, 0, "lw_10_kept");
        txn(0, 1, 3'd2, 32'h10, 32'h0BADF00D, 2, 1, 32'h0,        0, "sw_rst_acc");
        txn(1, 0, 3'd2, 32'h10, 32'h0,        0, 1, 32'hDEAD55EF, 0, "lw_10_nost");
        txn(1, 1, 3'd2, 32'h30, 32'hCAFEF00D, 0, 1, 32'hDEAD55EF, 0, "rdwr_30");
        txn(1, 0, 3'd2, 32'h30, 32'h0,        0, 1, 32'hCAFEF00D, 0, "lw_30");

        // Fill the random-traffic window so every model byte is defined.
        for (int w = 0; w < 16; w++)
            txn(0, 1, 3'd2, 32'(w * 4), $urandom, 0, 0, 32'h0, 0, "init");

        for (int k = 0; k < 400; k++) begin
            op   = int'($urandom_range(0, 2));
            rf   = 3'($urandom_range(0, 7));
            ra   = 32'($urandom_range(0, 63)) | ($urandom << 12);
            mode = (op == 0 && $urandom_range(0, 39) == 0) ? 1 : 0;
            txn(op != 1, op != 0, rf, ra, $urandom, mode, 0, 32'h0, 0, "rand");
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
